// File: rtl/uart_tx_sink.sv
// Packs decoded serial bits into bytes, buffers them in a small FIFO and sends them as UART frames.
// Define UART_PARITY_EN to insert an even-parity bit (8E1); otherwise frames are 8N1.
module uart_tx_sink #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned ADDR_W       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              bit_in,
    input  logic              byte_clr,
    output logic              tx,
    output logic              busy,
    output logic              overflow,
    output logic [ADDR_W:0]   fifo_level
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          part_q, part_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     level_q, level_d;
    logic                overflow_q, overflow_d;
    logic [BaudW-1:0]    baud_q, baud_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          shreg_q, shreg_d;
    logic                tx_q, tx_d;
    logic [7:0]          mem_q [DEPTH];

    logic       push, push_ok, pop, full, empty, baud_end;
    logic [7:0] push_byte;

    // Byte assembly; the 8th bit completes the byte on the same edge it arrives.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        part_d    = part_q;
        push      = 1'b0;
        push_byte = {bit_in, part_q[6:0]};
        if (byte_clr) begin
            bit_cnt_d = 3'd0;
            if (valid_in) begin
                part_d[0] = bit_in;
                bit_cnt_d = 3'd1;
            end
        end else if (valid_in) begin
            part_d[bit_cnt_q] = bit_in;
            bit_cnt_d         = bit_cnt_q + 3'd1;
            push              = (bit_cnt_q == 3'd7);
        end
    end

    assign full     = (level_q == (ADDR_W + 1)'(DEPTH));
    assign empty    = (level_q == '0);
    assign push_ok  = push & ~full;
    assign baud_end = (baud_q == BaudW'(CLKS_PER_BIT - 1));

    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        overflow_d = push & full;
        level_d    = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + (ADDR_W + 1)'(1);
        end else if (!push_ok && pop) begin
            level_d = level_q - (ADDR_W + 1)'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                baud_d = baud_q + BaudW'(1);
                if (baud_end) begin
                    baud_d  = '0;
                    idx_d   = 3'd0;
                    tx_d    = shreg_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                baud_d = baud_q + BaudW'(1);
                if (baud_end) begin
                    baud_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_d    = ^shreg_q;
                        state_d = StParity;
`else
                        tx_d    = 1'b1;
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shreg_q[idx_q + 3'd1];
                    end
                end
            end
            StParity: begin
                baud_d = baud_q + BaudW'(1);
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = StStop;
                end
            end
            StStop: begin
                baud_d = baud_q + BaudW'(1);
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            part_q     <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            baud_q     <= '0;
            idx_q      <= 3'd0;
            shreg_q    <= 8'd0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            part_q     <= part_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
        end
    end

    // Storage needs no reset: the pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    assign tx         = tx_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;
    assign busy       = (state_q != StIdle) | (level_q != '0);

endmodule

// File: tb/tb_uart_tx_sink.sv
// Scoreboard bench for uart_tx_sink: stimulus queues expected bytes, a line monitor decodes frames.
module tb_uart_tx_sink;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n, valid_in, bit_in, byte_clr;
    logic       tx, busy, overflow;
    logic [2:0] fifo_level;

    always #5 clk = ~clk;

    uart_tx_sink #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH),
        .ADDR_W       (2)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .valid_in   (valid_in),
        .bit_in     (bit_in),
        .byte_clr   (byte_clr),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    int         n_total = 0;
    int         n_pass  = 0;
    int         cyc     = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         ov_cnt  = 0;
    int         peak    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Line monitor: captures FRAME_CYC samples from the first low sample and decodes them.
    logic             smp [FRAME_CYC];
    logic [NBITS-1:0] bits;
    logic [7:0]       got, expb;
    bit               m_active, shape_ok;
    int               m_cnt;

    initial begin
        m_active = 1'b0;
        m_cnt    = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                m_active = 1'b0;
            end else begin
                if (!m_active && tx === 1'b0) begin
                    m_active = 1'b1;
                    m_cnt    = 0;
                    start_q.push_back(cyc);
                end
                if (m_active) begin
                    smp[m_cnt] = tx;
                    m_cnt++;
                    if (m_cnt == FRAME_CYC) begin
                        m_active = 1'b0;
                        shape_ok = 1'b1;
                        for (int b = 0; b < NBITS; b++) begin
                            bits[b] = smp[b*CPB];
                            for (int k = 1; k < CPB; k++)
                                if (smp[b*CPB+k] !== bits[b]) shape_ok = 1'b0;
                        end
                        if (bits[0] !== 1'b0 || bits[NBITS-1] !== 1'b1) shape_ok = 1'b0;
                        got = bits[8:1];
                        check("frame_shape", shape_ok, 1);
                        if (exp_q.size() == 0) begin
                            check("frame_unexpected", exp_q.size(), 1);
                        end else begin
                            expb = exp_q.pop_front();
                            check("frame_byte", got, expb);
`ifdef UART_PARITY_EN
                            check("frame_parity", bits[9], ^expb);
`endif
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (overflow === 1'b1) ov_cnt++;
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            byte_clr = 1'b0;
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        valid_in = 1'b1;
        bit_in   = b;
        byte_clr = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit expect_it);
        if (expect_it) exp_q.push_back(d);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
    endtask

    // Called right after the last bit of a byte was driven into an idle DUT.
    task automatic check_launch(input string tag);
        @(negedge clk);
        valid_in = 1'b0;
        check({tag, "_tx_before_fall"}, tx, 1);
        check({tag, "_level_after_push"}, fifo_level, 1);
        @(negedge clk);
        check({tag, "_tx_fall"}, tx, 0);
        check({tag, "_busy"}, busy, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  base;
    bit  line_ok;

    initial begin
        valid_in = 1'b0;
        bit_in   = 1'b0;
        byte_clr = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_level", fifo_level, 0);
        rst_n = 1'b1;
        idle(2);

        // T1: 0x09, launch timing and busy release after stop.
        send_byte(8'h09, 1'b1);
        check_launch("t1");
        repeat (FRAME_CYC - 1) @(negedge clk);
        check("t1_busy_in_stop", busy, 1);
        @(negedge clk);
        check("t1_busy_after_stop", busy, 0);
        check("t1_no_overflow", ov_cnt, 0);

        // T2: six streamed bytes, the sixth is dropped on a full FIFO.
        idle(2);
        wait_idle(200);
        ov_cnt = 0;
        peak   = 0;
        base   = start_q.size();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b0);
        idle(1);
        wait_idle(400);
        check("t2_overflow_pulses", ov_cnt, 1);
        check("t2_level_peak", peak, DEPTH);
        check("t2_frame_count", start_q.size() - base, 5);
        for (int i = 1; i < 5; i++)
            check("t2_frame_spacing", start_q[base+i] - start_q[base+i-1], FRAME_CYC + 1);

        // T3: byte_clr discards a partial byte; byte_clr with valid_in keeps that bit as bit 0.
        idle(2);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        byte_clr = 1'b1;
        @(negedge clk);
        byte_clr = 1'b0;
        send_byte(8'hA5, 1'b1);
        idle(1);
        wait_idle(200);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        exp_q.push_back(8'h3B);
        @(negedge clk);
        valid_in = 1'b1;
        bit_in   = 1'b1;
        byte_clr = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        idle(1);
        wait_idle(200);

        // T4: 0xFF with random gaps between bits.
        idle(2);
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 5));
            drive_bit(1'b1);
        end
        check_launch("t4");
        idle(1);
        wait_idle(200);

        // T5: reset during data bit 3 truncates the frame at once.
        idle(2);
        send_byte(8'h00, 1'b0);
        check_launch("t5");
        repeat (17) @(negedge clk);
        check("t5_data_bit3_low", tx, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_tx_async", tx, 1);
        check("t5_level_async", fifo_level, 0);
        check("t5_busy_async", busy, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        line_ok = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) line_ok = 1'b0;
        end
        check("t5_quiet_after_reset", line_ok, 1);

`ifdef UART_PARITY_EN
        // T6: parity values and 8E1 spacing.
        idle(2);
        wait_idle(200);
        base = start_q.size();
        send_byte(8'h07, 1'b1);
        send_byte(8'h09, 1'b1);
        idle(1);
        wait_idle(300);
        check("t6_frame_count", start_q.size() - base, 2);
        check("t6_frame_spacing", start_q[base+1] - start_q[base], FRAME_CYC + 1);
`endif

        idle(2);
        wait_idle(200);
        check("frames_pending", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
